// File: rtl/board_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// board_mem_arbiter_if
// Bundles every bus that meets the board-RAM arbiter: the renderer read
// port, the game-controller read/write port, the clear handshake and the
// single RAM port.
//   slave  modport : the arbiter's view (requests and RAM read data in;
//                    grants, read data and RAM controls out)
//   master modport : the users' and RAM's view (the mirror image)
// Parameters: ADDR_W board address width, DATA_W cell width.
// ----------------------------------------------------------------------------
interface board_mem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 2
);
    // renderer port
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    // game-controller port
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [DATA_W-1:0] game_wdata;
    logic              game_gnt;
    logic              game_rvalid;
    logic [DATA_W-1:0] game_rdata;
    // clear handshake
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    // RAM port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
               clr_start, mem_rdata,
        output disp_gnt, disp_valid, disp_data, game_gnt, game_rvalid,
               game_rdata, clr_busy, clr_done, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
               clr_start, mem_rdata,
        input  disp_gnt, disp_valid, disp_data, game_gnt, game_rvalid,
               game_rdata, clr_busy, clr_done, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// ----------------------------------------------------------------------------
// board_mem_arbiter
// Shares the single port of the 2-bit-per-cell game-board RAM between the
// VGA renderer (reads), the game controller (reads/writes) and an internal
// clear sequencer that zeroes cells 0..DEPTH-1. One RAM access per cycle.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - board_mem_arbiter_if.slave (renderer, controller, clear, RAM)
// Grants and RAM controls are combinational in the grant cycle; read
// valids follow one cycle later, aligned with the RAM's registered data.
// ----------------------------------------------------------------------------
module board_mem_arbiter #(
    parameter int ADDR_W        = 7,
    parameter int DATA_W        = 2,
    parameter int DEPTH         = 100,
    parameter int GAME_MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    board_mem_arbiter_if.slave  bus
);
    localparam int WAIT_W = $clog2(GAME_MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(GAME_MAX_WAIT);

    typedef enum logic [0:0] {ARB = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] clr_cnt_r, clr_cnt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic              disp_gnt_s, game_gnt_s, clr_done_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              game_in_range_s;
    logic              disp_valid_r, game_rvalid_r, game_oor_r, clr_done_r;

    assign game_in_range_s = (bus.game_addr < DEPTH_A);

    // Next-state, grant selection and RAM port drive.
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        disp_gnt_s  = 1'b0;
        game_gnt_s  = 1'b0;
        clr_done_s  = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_we_s    = 1'b0;
        mem_wdata_s = {DATA_W{1'b0}};
        if (rst) begin
            // Outputs stay quiet while reset is held; state reloads.
            state_s    = ARB;
            clr_cnt_s  = {ADDR_W{1'b0}};
            wait_cnt_s = {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                ARB: begin
                    if (bus.clr_start) begin
                        state_s   = CLEAR;
                        clr_cnt_s = {ADDR_W{1'b0}};
                    end else if (bus.game_req && (wait_cnt_r == WAIT_MAX)) begin
                        game_gnt_s = 1'b1;   // starved controller pre-empts the display
                    end else if (bus.disp_req) begin
                        disp_gnt_s = 1'b1;
                    end else if (bus.game_req) begin
                        game_gnt_s = 1'b1;
                    end else begin
                        game_gnt_s = 1'b0;
                    end

                    if (game_gnt_s) begin
                        mem_addr_s = bus.game_addr;
                        // Out-of-range writes are granted but never reach the RAM.
                        mem_we_s    = bus.game_we & game_in_range_s;
                        mem_wdata_s = bus.game_we ? bus.game_wdata : {DATA_W{1'b0}};
                    end else if (disp_gnt_s) begin
                        mem_addr_s = bus.disp_addr;
                    end else begin
                        mem_addr_s = {ADDR_W{1'b0}};
                    end

                    if (bus.game_req && !game_gnt_s) begin
                        wait_cnt_s = (wait_cnt_r == WAIT_MAX) ? WAIT_MAX
                                                              : wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        wait_cnt_s = {WAIT_W{1'b0}};
                    end
                end
                CLEAR: begin
                    // wait_cnt is frozen and clr_start ignored while clearing.
                    mem_addr_s = clr_cnt_r;
                    mem_we_s   = 1'b1;
                    if (clr_cnt_r == LAST_A) begin
                        state_s    = ARB;
                        clr_cnt_s  = {ADDR_W{1'b0}};
                        clr_done_s = 1'b1;
                    end else begin
                        clr_cnt_s = clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = ARB;
                end
            endcase
        end
    end

    // State, counters and one-cycle-delayed read/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ARB;
            clr_cnt_r     <= {ADDR_W{1'b0}};
            wait_cnt_r    <= {WAIT_W{1'b0}};
            disp_valid_r  <= 1'b0;
            game_rvalid_r <= 1'b0;
            game_oor_r    <= 1'b0;
            clr_done_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            clr_cnt_r     <= clr_cnt_s;
            wait_cnt_r    <= wait_cnt_s;
            disp_valid_r  <= disp_gnt_s;
            game_rvalid_r <= game_gnt_s & ~bus.game_we;
            game_oor_r    <= game_gnt_s & ~bus.game_we & ~game_in_range_s;
            clr_done_r    <= clr_done_s;
        end
    end

    // Flags are masked during reset so every output reads 0 in the reset cycle.
    assign bus.disp_gnt    = disp_gnt_s;
    assign bus.game_gnt    = game_gnt_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_we      = mem_we_s;
    assign bus.mem_wdata   = mem_wdata_s;
    assign bus.disp_valid  = disp_valid_r & ~rst;
    assign bus.disp_data   = (disp_valid_r && !rst) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.game_rvalid = game_rvalid_r & ~rst;
    assign bus.game_rdata  = (game_rvalid_r && !game_oor_r && !rst) ? bus.mem_rdata
                                                                     : {DATA_W{1'b0}};
    assign bus.clr_busy    = (state_r == CLEAR) & ~rst;
    assign bus.clr_done    = clr_done_r & ~rst;
endmodule

// File: tb/tb_board_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_board_mem_arbiter
// Directed bench for board_mem_arbiter with a behavioural 1-cycle-latency
// board RAM. Inputs change just after the falling edge; outputs are
// sampled 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_board_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    board_mem_arbiter_if #(.ADDR_W(7), .DATA_W(2)) bus ();

    board_mem_arbiter #(
        .ADDR_W(7), .DATA_W(2), .DEPTH(100), .GAME_MAX_WAIT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [1:0] ram [0:127];
    int vec = 0;
    int err = 0;

    // Behavioural single-port RAM with registered read data.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    function automatic logic [1:0] pat(input int i);
        return 2'((i % 3) + 1);
    endfunction

    task automatic idle_inputs();
        bus.disp_req = 1'b0; bus.disp_addr = 7'd0;
        bus.game_req = 1'b0; bus.game_we = 1'b0;
        bus.game_addr = 7'd0; bus.game_wdata = 2'd0;
        bus.clr_start = 1'b0;
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.game_req = 1'b1; bus.game_we = 1'b1;
            bus.game_addr = 7'(i); bus.game_wdata = pat(i);
            #1;
            vec++;
            if (bus.game_gnt !== 1'b1 || bus.mem_we !== 1'b1) begin
                err++; $display("FAIL fill_gnt addr=%0d gnt=%b we=%b expected 1/1", i, bus.game_gnt, bus.mem_we);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.disp_req = 1'b1; bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 7'd9;
        #1;
        vec++;
        if ({bus.disp_gnt, bus.game_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.disp_valid, bus.game_rvalid, bus.clr_busy, bus.clr_done} !== 16'd0) begin
            err++; $display("FAIL reset_outputs dgnt=%b ggnt=%b we=%b addr=%0d expected all 0",
                            bus.disp_gnt, bus.game_gnt, bus.mem_we, bus.mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        vec++;
        if (bus.disp_valid !== 1'b0 || bus.clr_busy !== 1'b0 || bus.disp_data !== 2'b00) begin
            err++; $display("FAIL reset_release dvalid=%b busy=%b ddata=%b expected 0", bus.disp_valid, bus.clr_busy, bus.disp_data);
        end
    endtask

    task automatic test_disp_read();
        @(negedge clk);
        bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 7'd5; bus.game_wdata = 2'b01;
        @(negedge clk);
        idle_inputs();
        bus.disp_req = 1'b1; bus.disp_addr = 7'd5;
        #1;
        vec++;
        if (bus.disp_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 7'd5) begin
            err++; $display("FAIL disp_gnt gnt=%b we=%b addr=%0d expected 1/0/5", bus.disp_gnt, bus.mem_we, bus.mem_addr);
        end
        @(negedge clk);
        bus.disp_req = 1'b0;
        #1;
        vec++;
        if (bus.disp_valid !== 1'b1 || bus.disp_data !== 2'b01 || bus.game_rvalid !== 1'b0) begin
            err++; $display("FAIL disp_data valid=%b data=%b expected 1/01", bus.disp_valid, bus.disp_data);
        end
    endtask

    task automatic test_starvation();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.disp_req = 1'b1; bus.disp_addr = 7'd0;
            bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 7'd23; bus.game_wdata = 2'b10;
            #1;
            vec++;
            if (k < 5) begin
                if (bus.disp_gnt !== 1'b1 || bus.game_gnt !== 1'b0) begin
                    err++; $display("FAIL starve_refuse k=%0d dgnt=%b ggnt=%b expected 1/0", k, bus.disp_gnt, bus.game_gnt);
                end
            end else begin
                if (bus.game_gnt !== 1'b1 || bus.disp_gnt !== 1'b0 || bus.mem_we !== 1'b1 ||
                    bus.mem_addr !== 7'd23 || bus.mem_wdata !== 2'b10 || bus.disp_valid !== 1'b1) begin
                    err++; $display("FAIL starve_grant ggnt=%b dgnt=%b we=%b addr=%0d wd=%b dval=%b expected 1/0/1/23/10/1",
                                    bus.game_gnt, bus.disp_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.disp_valid);
                end
            end
        end
        @(negedge clk);
        bus.game_req = 1'b0;
        #1;
        vec++;
        if (bus.disp_gnt !== 1'b1 || bus.disp_valid !== 1'b0) begin
            err++; $display("FAIL starve_after dgnt=%b dval=%b expected 1/0", bus.disp_gnt, bus.disp_valid);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vec++;
        if (ram[23] !== 2'b10) begin
            err++; $display("FAIL starve_ram ram23=%b expected 10", ram[23]);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 7'd100; bus.game_wdata = 2'b11;
        #1;
        vec++;
        if (bus.game_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
            err++; $display("FAIL oor_write gnt=%b we=%b expected 1/0", bus.game_gnt, bus.mem_we);
        end
        @(negedge clk);
        bus.game_we = 1'b0; bus.game_addr = 7'd127;
        #1;
        vec++;
        if (bus.game_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
            err++; $display("FAIL oor_read_gnt gnt=%b we=%b expected 1/0", bus.game_gnt, bus.mem_we);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vec++;
        if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 2'b00) begin
            err++; $display("FAIL oor_read_data rvalid=%b rdata=%b expected 1/00", bus.game_rvalid, bus.game_rdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.disp_req = 1'b1; bus.disp_addr = 7'd23;
        #1;
        vec++;
        if (bus.disp_gnt !== 1'b1) begin
            err++; $display("FAIL b2b_disp_gnt gnt=%b expected 1", bus.disp_gnt);
        end
        @(negedge clk);
        bus.disp_req = 1'b0;
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 7'd5;
        #1;
        vec++;
        if (bus.game_gnt !== 1'b1 || bus.disp_valid !== 1'b1 || bus.disp_data !== 2'b10 || bus.game_rvalid !== 1'b0) begin
            err++; $display("FAIL b2b_mid ggnt=%b dval=%b ddata=%b grv=%b expected 1/1/10/0",
                            bus.game_gnt, bus.disp_valid, bus.disp_data, bus.game_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vec++;
        if (bus.game_rvalid !== 1'b1 || bus.game_rdata !== 2'b01 || bus.disp_valid !== 1'b0) begin
            err++; $display("FAIL b2b_game_read grv=%b grd=%b dval=%b expected 1/01/0",
                            bus.game_rvalid, bus.game_rdata, bus.disp_valid);
        end
    endtask

    task automatic test_clear();
        int busy = 0;
        bit done_seen = 1'b0;
        bit addr_ok = 1'b1;
        int zeros = 0;
        @(negedge clk);
        bus.clr_start = 1'b1;
        bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 7'd7;
        #1;
        vec++;
        if (bus.game_gnt !== 1'b0 || bus.disp_gnt !== 1'b0 || bus.mem_we !== 1'b0 || bus.clr_busy !== 1'b0) begin
            err++; $display("FAIL clr_start_cycle ggnt=%b dgnt=%b we=%b busy=%b expected 0/0/0/0",
                            bus.game_gnt, bus.disp_gnt, bus.mem_we, bus.clr_busy);
        end
        for (int c = 0; c < 150 && !done_seen; c++) begin
            @(negedge clk);
            bus.clr_start = 1'b0;
            #1;
            if (bus.clr_busy === 1'b1) begin
                if (bus.game_gnt !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 7'(busy) ||
                    bus.mem_wdata !== 2'b00 || bus.clr_done !== 1'b0) addr_ok = 1'b0;
                busy++;
            end else begin
                done_seen = 1'b1;
                vec++;
                if (bus.clr_done !== 1'b1 || bus.game_gnt !== 1'b1) begin
                    err++; $display("FAIL clr_done_cycle done=%b ggnt=%b expected 1/1", bus.clr_done, bus.game_gnt);
                end
            end
        end
        vec++;
        if (!done_seen || busy != 100 || !addr_ok) begin
            err++; $display("FAIL clr_sequence done_seen=%0d busy=%0d addr_ok=%0d expected 1/100/1", done_seen, busy, addr_ok);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        vec++;
        if (bus.clr_done !== 1'b0 || bus.game_rvalid !== 1'b1 || bus.game_rdata !== 2'b00) begin
            err++; $display("FAIL clr_after done=%b grv=%b grd=%b expected 0/1/00", bus.clr_done, bus.game_rvalid, bus.game_rdata);
        end
        for (int i = 0; i < 100; i++) if (ram[i] === 2'b00) zeros++;
        vec++;
        if (zeros != 100) begin
            err++; $display("FAIL clr_ram_zero zero_cells=%0d expected 100", zeros);
        end
    endtask

    task automatic test_reset_mid_clear();
        int bad_idle = 0;
        int kept = 0;
        int cleared = 0;
        fill_pattern();
        @(negedge clk);
        bus.clr_start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.clr_start = 1'b0;
        end
        #1;
        vec++;
        if (bus.clr_busy !== 1'b1 || bus.mem_addr !== 7'd39) begin
            err++; $display("FAIL rstclr_pre busy=%b addr=%0d expected 1/39", bus.clr_busy, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if ({bus.mem_we, bus.mem_addr, bus.clr_busy, bus.clr_done, bus.disp_gnt, bus.game_gnt} !== 12'd0) begin
            err++; $display("FAIL rstclr_outputs we=%b addr=%0d busy=%b done=%b expected 0", bus.mem_we, bus.mem_addr, bus.clr_busy, bus.clr_done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 110; c++) begin
            #1;
            if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0 || bus.mem_we !== 1'b0) bad_idle++;
            @(negedge clk);
        end
        vec++;
        if (bad_idle != 0) begin
            err++; $display("FAIL rstclr_idle bad_cycles=%0d expected 0", bad_idle);
        end
        for (int i = 0; i < 40; i++) if (ram[i] === 2'b00) cleared++;
        for (int i = 40; i < 100; i++) if (ram[i] === pat(i)) kept++;
        vec++;
        if (cleared != 40 || kept != 60) begin
            err++; $display("FAIL rstclr_ram cleared=%0d kept=%0d expected 40/60", cleared, kept);
        end
        bus.disp_req = 1'b1; bus.disp_addr = 7'd50;
        #1;
        vec++;
        if (bus.disp_gnt !== 1'b1) begin
            err++; $display("FAIL rstclr_arb dgnt=%b expected 1", bus.disp_gnt);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_restart_ignored();
        int busy = 0;
        int dones = 0;
        logic [6:0] last_addr = 7'd0;
        @(negedge clk);
        bus.clr_start = 1'b1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            bus.clr_start = (c == 10);
            #1;
            if (bus.clr_busy === 1'b1) begin
                busy++;
                last_addr = bus.mem_addr;
            end
            if (bus.clr_done === 1'b1) dones++;
        end
        vec++;
        if (busy != 100 || dones != 1 || last_addr !== 7'd99) begin
            err++; $display("FAIL restart_ignored busy=%0d dones=%0d last=%0d expected 100/1/99", busy, dones, last_addr);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        fill_pattern();
        test_disp_read();
        test_starvation();
        test_out_of_range();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        test_restart_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
